// File: rtl/seq_det_pkg.sv
// Shared constants and width helpers for the serial multi-pattern detector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   f_len_w  - bits needed to hold a length/fill value 0..max_len
//   f_id_w   - bits needed to hold a slot index 0..num_pat-1
//   LEGACY_* - slot contents restored at reset so older lab top-levels keep
//              their fixed "1111" / "1101" detector behaviour
package seq_det_pkg;

   localparam logic [3:0]  LEGACY_PAT0 = 4'b1111;
   localparam logic [3:0]  LEGACY_PAT1 = 4'b1101;
   localparam int unsigned LEGACY_LEN  = 4;

   function automatic int f_len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   // A single-slot build would give $clog2(1) = 0, so keep at least one bit.
   function automatic int f_id_w(input int num_pat);
      return (num_pat > 1) ? $clog2(num_pat) : 1;
   endfunction

endpackage

// File: rtl/seq_pat_slot.sv
// One programmable pattern slot: stores pattern/length and compares them against the next history.
// Latency: match_o is combinational from hist_nxt_i/fill_nxt_i; slot contents update on the edge.
// Backpressure: none; a write is accepted on every cycle wr_i is high.
//
// Ports:
//   Clock, Resetn  clock and synchronous active-low reset
//   wr_i           write this slot at the edge
//   wr_pat_i       pattern bits, wr_pat_i[len-1] is the first bit received
//   wr_len_i       pattern length; 0 disables, values above MAX_LEN clamp to MAX_LEN
//   hist_nxt_i     history as it would be after the current bit, bit 0 newest
//   fill_nxt_i     number of valid bits in hist_nxt_i
//   match_o        slot is enabled, enough history exists and the newest bits equal the pattern
module seq_pat_slot
   import seq_det_pkg::*;
#(
   parameter int                 MAX_LEN = 8,
   parameter int                 LEN_W   = f_len_w(MAX_LEN),
   parameter logic [MAX_LEN-1:0] RST_PAT = '0,
   parameter logic [LEN_W-1:0]   RST_LEN = '0
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic               wr_i,
   input  logic [MAX_LEN-1:0] wr_pat_i,
   input  logic [LEN_W-1:0]   wr_len_i,
   input  logic [MAX_LEN-1:0] hist_nxt_i,
   input  logic [LEN_W-1:0]   fill_nxt_i,
   output logic               match_o
);

   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   wr_len_clamped;
   logic [MAX_LEN-1:0] cmp_mask;

   // Ones in bit positions below len, i.e. the bits that take part in a compare.
   function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
      logic [MAX_LEN-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         m[i] = (LEN_W'(i) < len);
      end
      return m;
   endfunction

   always_comb begin
      wr_len_clamped = (wr_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : wr_len_i;
      pat_d          = pat_q;
      len_d          = len_q;
      if (wr_i) begin
         // Bits above the length are stored as zero so the register contents
         // always reflect exactly what is being matched.
         pat_d = wr_pat_i & len_mask(wr_len_clamped);
         len_d = wr_len_clamped;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         pat_q <= RST_PAT;
         len_q <= RST_LEN;
      end else begin
         pat_q <= pat_d;
         len_q <= len_d;
      end
   end

   // Compare only the newest len_q bits; a pattern cannot match before that
   // many bits have arrived since the last clear.
   always_comb begin
      cmp_mask = len_mask(len_q);
      match_o  = (len_q != '0) &&
                 (fill_nxt_i >= len_q) &&
                 (((hist_nxt_i ^ pat_q) & cmp_mask) == '0);
   end

endmodule

// File: rtl/seq_multi_pattern_detector.sv
// Runtime-programmable serial detector: flags when the newest bits of w equal any stored pattern.
// Latency: z/match_id registered, high one cycle after the edge that samples the last pattern bit.
// Backpressure: none; a bit is consumed on every edge with en=1 and load=0.
//
// Ports:
//   Clock, Resetn  clock and synchronous active-low reset (slots return to 1111 / 1101)
//   w, en          serial bit and its sample enable
//   overlap        1 keeps history after a match, 0 clears it
//   load, load_sel, load_pat, load_len  program one slot; also clears history
//   clr_count      zero match_count (wins over a simultaneous increment)
//   z, match_id    match pulse and lowest matching slot index
//   match_count    saturating number of match pulses
//   fill           number of valid history bits
module seq_multi_pattern_detector
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int NUM_PAT = 4,
   parameter int CNT_W   = 8
) (
   input  logic                         Clock,
   input  logic                         Resetn,
   input  logic                         w,
   input  logic                         en,
   input  logic                         overlap,
   input  logic                         load,
   input  logic [f_id_w(NUM_PAT)-1:0]   load_sel,
   input  logic [MAX_LEN-1:0]           load_pat,
   input  logic [f_len_w(MAX_LEN)-1:0]  load_len,
   input  logic                         clr_count,
   output logic                         z,
   output logic [f_id_w(NUM_PAT)-1:0]   match_id,
   output logic [CNT_W-1:0]             match_count,
   output logic [f_len_w(MAX_LEN)-1:0]  fill
);

   localparam int LEN_W = f_len_w(MAX_LEN);
   localparam int ID_W  = f_id_w(NUM_PAT);

   // The oldest history bit is shifted out before any compare can see it,
   // so only MAX_LEN-1 bits are kept; the incoming w completes the window.
   logic [MAX_LEN-2:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               z_q, z_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [MAX_LEN-1:0] hist_nxt;
   logic [LEN_W-1:0]   fill_nxt;
   logic [NUM_PAT-1:0] slot_hit;
   logic               any_hit;
   logic [ID_W-1:0]    hit_id;

   // Candidate history including this cycle's bit.
   always_comb begin
      hist_nxt = {hist_q, w};
      fill_nxt = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
   end

   for (genvar p = 0; p < NUM_PAT; p++) begin : g_slot
      localparam logic [MAX_LEN-1:0] RST_PAT =
         (p == 0) ? MAX_LEN'(LEGACY_PAT0) :
         (p == 1) ? MAX_LEN'(LEGACY_PAT1) : '0;
      localparam logic [LEN_W-1:0] RST_LEN =
         (p < 2) ? LEN_W'(LEGACY_LEN) : '0;

      seq_pat_slot #(
         .MAX_LEN (MAX_LEN),
         .LEN_W   (LEN_W),
         .RST_PAT (RST_PAT),
         .RST_LEN (RST_LEN)
      ) u_slot (
         .Clock      (Clock),
         .Resetn     (Resetn),
         .wr_i       (load && (load_sel == ID_W'(p))),
         .wr_pat_i   (load_pat),
         .wr_len_i   (load_len),
         .hist_nxt_i (hist_nxt),
         .fill_nxt_i (fill_nxt),
         .match_o    (slot_hit[p])
      );
   end

   // Lowest index wins: scan from the top so the last assignment is the lowest hit.
   always_comb begin
      hit_id = '0;
      for (int p = NUM_PAT - 1; p >= 0; p--) begin
         if (slot_hit[p]) begin
            hit_id = ID_W'(p);
         end
      end
      any_hit = |slot_hit;
   end

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      z_d    = 1'b0;
      id_d   = '0;
      cnt_d  = cnt_q;

      if (load) begin
         // Reprogramming invalidates any partial match; this cycle's w is dropped.
         hist_d = '0;
         fill_d = '0;
      end else if (en) begin
         hist_d = hist_nxt[MAX_LEN-2:0];
         fill_d = fill_nxt;
         if (any_hit) begin
            z_d  = 1'b1;
            id_d = hit_id;
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (!overlap) begin
               hist_d = '0;
               fill_d = '0;
            end
         end
      end

      if (clr_count) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         hist_q <= '0;
         fill_q <= '0;
         z_q    <= 1'b0;
         id_q   <= '0;
         cnt_q  <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         z_q    <= z_d;
         id_q   <= id_d;
         cnt_q  <= cnt_d;
      end
   end

   assign z           = z_q;
   assign match_id    = id_q;
   assign match_count = cnt_q;
   assign fill        = fill_q;

endmodule

// File: tb/tb_seq_multi_pattern_detector.sv
// Bench for seq_multi_pattern_detector: directed vector table, hand-written counter
// corner cases, then randomized traffic checked against a bit-queue reference model.
// A second instance with a 2-bit counter shares all inputs to exercise saturation.
module tb_seq_multi_pattern_detector;

   logic       Clock;
   logic       Resetn;
   logic       w, en, overlap, load, clr_count;
   logic [1:0] load_sel;
   logic [7:0] load_pat;
   logic [3:0] load_len;

   logic       z, z2;
   logic [1:0] match_id, match_id2;
   logic [7:0] match_count;
   logic [1:0] match_count2;
   logic [3:0] fill, fill2;

   int n_cmp = 0;
   int n_bad = 0;

   seq_multi_pattern_detector #(.MAX_LEN(8), .NUM_PAT(4), .CNT_W(8)) dut (
      .Clock(Clock), .Resetn(Resetn), .w(w), .en(en), .overlap(overlap),
      .load(load), .load_sel(load_sel), .load_pat(load_pat), .load_len(load_len),
      .clr_count(clr_count), .z(z), .match_id(match_id),
      .match_count(match_count), .fill(fill)
   );

   seq_multi_pattern_detector #(.MAX_LEN(8), .NUM_PAT(4), .CNT_W(2)) dut_sat (
      .Clock(Clock), .Resetn(Resetn), .w(w), .en(en), .overlap(overlap),
      .load(load), .load_sel(load_sel), .load_pat(load_pat), .load_len(load_len),
      .clr_count(clr_count), .z(z2), .match_id(match_id2),
      .match_count(match_count2), .fill(fill2)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
      $fatal(1);
   end

   // ---------------- reference model: received bits kept as a queue ----------------
   bit         mq[$];          // bits since last clear, oldest at front
   int         m_len [4];
   logic [7:0] m_pat [4];
   int         m_z, m_id, m_cnt, m_cnt2;

   function automatic void model_reset();
      mq.delete();
      m_pat[0] = 8'h0F; m_len[0] = 4;
      m_pat[1] = 8'h0D; m_len[1] = 4;
      m_pat[2] = 8'h00; m_len[2] = 0;
      m_pat[3] = 8'h00; m_len[3] = 0;
      m_z = 0; m_id = 0; m_cnt = 0; m_cnt2 = 0;
   endfunction

   // A pattern of length L matches when the last L received bits, read oldest
   // to newest, spell pat[L-1] down to pat[0].
   function automatic bit pat_seen(int p);
      int L = m_len[p];
      int n = mq.size();
      if (L == 0 || n < L) return 1'b0;
      for (int k = 0; k < L; k++) begin
         if (mq[n - L + k] != m_pat[p][L - 1 - k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic void model_step(bit wi, bit eni, bit ovi, bit ldi, int seli,
                                      logic [7:0] pati, int leni, bit clri);
      int hit = -1;
      m_z = 0; m_id = 0;
      if (ldi) begin
         m_pat[seli] = pati;
         m_len[seli] = (leni > 8) ? 8 : leni;
         mq.delete();
      end else if (eni) begin
         mq.push_back(wi);
         if (mq.size() > 8) void'(mq.pop_front());
         for (int p = 3; p >= 0; p--) if (pat_seen(p)) hit = p;
         if (hit >= 0) begin
            m_z = 1; m_id = hit;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
            if (!ovi) mq.delete();
         end
      end
      if (clri) begin m_cnt = 0; m_cnt2 = 0; end
   endfunction

   // ---------------- drive / check helpers ----------------
   task automatic step(input bit rst, input bit wi, input bit eni, input bit ovi,
                       input bit ldi, input int seli, input logic [7:0] pati,
                       input int leni, input bit clri);
      Resetn = !rst; w = wi; en = eni; overlap = ovi; load = ldi;
      load_sel = 2'(seli); load_pat = pati; load_len = 4'(leni); clr_count = clri;
      @(posedge Clock);
      #1;
      if (rst) model_reset();
      else     model_step(wi, eni, ovi, ldi, seli, pati, leni, clri);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit         rst, w, en, ovl, ld;
      int         sel;
      logic [7:0] pat;
      int         len;
      bit         ez;
      int         eid, ecnt, efill;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit rst, bit wi, bit eni, bit ovl, bit ld, int sel,
                               logic [7:0] pat, int len, bit ez, int eid, int ecnt, int efill);
      vec_t v;
      v.rst = rst; v.w = wi; v.en = eni; v.ovl = ovl; v.ld = ld;
      v.sel = sel; v.pat = pat; v.len = len;
      v.ez = ez; v.eid = eid; v.ecnt = ecnt; v.efill = efill;
      tbl.push_back(v);
   endfunction

   function automatic void rs();
      add(1, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
   endfunction

   function automatic void bt(bit wi, bit ovl, bit ez, int eid, int ecnt, int efill);
      add(0, wi, 1, ovl, 0, 0, 8'h00, 0, ez, eid, ecnt, efill);
   endfunction

   function automatic void ld(int sel, logic [7:0] pat, int len, int ecnt);
      add(0, 1, 1, 1, 1, sel, pat, len, 0, 0, ecnt, 0);
   endfunction

   initial begin
      Resetn = 1'b0; w = 0; en = 0; overlap = 1; load = 0;
      load_sel = 0; load_pat = 0; load_len = 0; clr_count = 0;
      model_reset();

      // legacy 1111, overlapping
      rs();
      bt(1,1, 0,0,0,1); bt(1,1, 0,0,0,2); bt(1,1, 0,0,0,3);
      bt(1,1, 1,0,1,4); bt(1,1, 1,0,2,5);
      add(0, 1, 0, 1, 0, 0, 8'h00, 0, 0, 0, 2, 5);          // en=0 holds
      // legacy 1101, then 0110 gives nothing
      rs();
      bt(1,1, 0,0,0,1); bt(1,1, 0,0,0,2); bt(0,1, 0,0,0,3); bt(1,1, 1,1,1,4);
      bt(0,1, 0,0,1,5); bt(1,1, 0,0,1,6); bt(1,1, 0,0,1,7); bt(0,1, 0,0,1,8);
      // non-overlapping: 1 x8 -> matches at 4 and 8 only
      rs();
      bt(1,0, 0,0,0,1); bt(1,0, 0,0,0,2); bt(1,0, 0,0,0,3); bt(1,0, 1,0,1,0);
      bt(1,0, 0,0,1,1); bt(1,0, 0,0,1,2); bt(1,0, 0,0,1,3); bt(1,0, 1,0,2,0);
      // mid-stream load of slot2 = 101 (junk above len), then 1,0,1,0,1
      bt(1,1, 0,0,2,1);
      ld(2, 8'hFD, 3, 2);
      bt(1,1, 0,0,2,1); bt(0,1, 0,0,2,2); bt(1,1, 1,2,3,3);
      bt(0,1, 0,0,3,4); bt(1,1, 1,2,4,5);
      // slot3 = 111: alone at bit 3, together with slot0 at bit 4 -> lowest id
      ld(3, 8'h07, 3, 4);
      bt(1,1, 0,0,4,1); bt(1,1, 0,0,4,2); bt(1,1, 1,3,5,3); bt(1,1, 1,0,6,4);
      // length 15 clamps to 8
      rs();
      ld(2, 8'b1011_0011, 15, 0);
      bt(1,1, 0,0,0,1); bt(0,1, 0,0,0,2); bt(1,1, 0,0,0,3); bt(1,1, 0,0,0,4);
      bt(0,1, 0,0,0,5); bt(0,1, 0,0,0,6); bt(1,1, 0,0,0,7); bt(1,1, 1,2,1,8);
      // reset mid-pattern, then disabling slot0
      rs();
      bt(1,1, 0,0,0,1); bt(1,1, 0,0,0,2); bt(1,1, 0,0,0,3);
      rs();
      bt(1,1, 0,0,0,1);
      ld(0, 8'h0F, 0, 0);
      bt(1,1, 0,0,0,1); bt(1,1, 0,0,0,2); bt(1,1, 0,0,0,3); bt(1,1, 0,0,0,4);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].w, tbl[i].en, tbl[i].ovl, tbl[i].ld,
              tbl[i].sel, tbl[i].pat, tbl[i].len, 1'b0);
         chk($sformatf("vec%0d.z", i),     int'(z),           int'(tbl[i].ez));
         chk($sformatf("vec%0d.id", i),    int'(match_id),    tbl[i].eid);
         chk($sformatf("vec%0d.count", i), int'(match_count), tbl[i].ecnt);
         chk($sformatf("vec%0d.fill", i),  int'(fill),        tbl[i].efill);
         chk($sformatf("vec%0d.count2", i), int'(match_count2),
             (tbl[i].ecnt > 3) ? 3 : tbl[i].ecnt);
      end

      // ---------------- hand sequence: saturation and clear priority ----------------
      step(1, 0, 0, 1, 0, 0, 8'h00, 0, 0);
      chk("sat.reset_count", int'(match_count2), 0);
      for (int k = 1; k <= 8; k++) begin
         step(0, 1, 1, 1, 0, 0, 8'h00, 0, 0);
         if (k >= 4) begin
            chk($sformatf("sat.bit%0d.z", k),      int'(z2),           1);
            chk($sformatf("sat.bit%0d.count2", k), int'(match_count2), (k - 3 > 3) ? 3 : k - 3);
            chk($sformatf("sat.bit%0d.count", k),  int'(match_count),  k - 3);
         end
      end
      step(0, 1, 1, 1, 0, 0, 8'h00, 0, 1);       // match and clear on same edge
      chk("clr.z",      int'(z),            1);
      chk("clr.count",  int'(match_count),  0);
      chk("clr.count2", int'(match_count2), 0);
      step(0, 1, 1, 1, 0, 0, 8'h00, 0, 0);
      chk("post_clr.count",  int'(match_count),  1);
      chk("post_clr.count2", int'(match_count2), 1);

      // ---------------- randomized traffic vs reference model ----------------
      step(1, 0, 0, 1, 0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         bit         r_rst, r_w, r_en, r_ovl, r_ld, r_clr;
         int         r_sel, r_len;
         logic [7:0] r_pat;
         r_rst = ($urandom_range(0, 299) == 0);
         r_ld  = ($urandom_range(0, 39) == 0);
         r_en  = ($urandom_range(0, 9) != 0);
         r_ovl = 1'($urandom_range(0, 1));
         r_clr = ($urandom_range(0, 79) == 0);
         r_w   = 1'($urandom_range(0, 1));
         r_sel = $urandom_range(0, 3);
         r_pat = 8'($urandom);
         r_len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 5);
         step(r_rst, r_w, r_en, r_ovl, r_ld, r_sel, r_pat, r_len, r_clr);
         chk($sformatf("rnd%0d.z", i),      int'(z),            m_z);
         chk($sformatf("rnd%0d.id", i),     int'(match_id),     m_id);
         chk($sformatf("rnd%0d.count", i),  int'(match_count),  m_cnt);
         chk($sformatf("rnd%0d.count2", i), int'(match_count2), m_cnt2);
         chk($sformatf("rnd%0d.fill", i),   int'(fill),         mq.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
